wb_write_post_buffer: RTL and testbench



---
 rtl/wb_write_post_buffer.sv | 161 ++++++++++++++++
 tb/tb_wb_write_post_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_post_buffer.sv
// Write-posting buffer: upstream Wishbone writes are acked on enqueue and replayed in order
// downstream; reads wait for the queue to drain, then pass through as single transfers.
module wb_write_post_buffer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [31:0]           wb_s_adr_i,
  input  logic [31:0]           wb_s_dat_i,
  input  logic [3:0]            wb_s_sel_i,
  input  logic                  wb_s_we_i,
  input  logic                  wb_s_stb_i,
  input  logic                  wb_s_cyc_i,
  output logic [31:0]           wb_s_dat_o,
  output logic                  wb_s_ack_o,
  output logic [31:0]           wb_m_adr_o,
  output logic [31:0]           wb_m_dat_o,
  output logic [3:0]            wb_m_sel_o,
  output logic                  wb_m_we_o,
  output logic                  wb_m_stb_o,
  output logic                  wb_m_cyc_o,
  input  logic [31:0]           wb_m_dat_i,
  input  logic                  wb_m_ack_i,
  output logic [DEPTH_LOG2:0]   buf_level_o,
  output logic                  buf_empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } m_state_t;

  logic [31:0]           adr_mem [DEPTH];
  logic [31:0]           dat_mem [DEPTH];
  logic [3:0]            sel_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [LW-1:0]         level_r;
  m_state_t              state_r;
  logic                  rd_pend_r;

  logic                  s_ack_r;
  logic [31:0]           s_dat_r;
  logic [31:0]           m_adr_r;
  logic [31:0]           m_dat_r;
  logic [3:0]            m_sel_r;
  logic                  m_we_r;
  logic                  m_cyc_r;

  logic                  full_s;
  logic                  req_s;
  logic                  push_s;
  logic                  rd_req_s;
  logic                  pop_s;
  logic                  rd_done_s;
  logic                  rd_deliver_s;

  // Request decode; a request is ignored during its own ack cycle.
  always_comb begin
    full_s       = (level_r == LW'(DEPTH));
    req_s        = wb_s_stb_i & wb_s_cyc_i & ~s_ack_r;
    push_s       = req_s & wb_s_we_i & ~full_s;
    rd_req_s     = req_s & ~wb_s_we_i;
    pop_s        = (state_r == M_WRITE) & wb_m_ack_i;
    rd_done_s    = (state_r == M_READ) & wb_m_ack_i;
    rd_deliver_s = rd_done_s & wb_s_stb_i & wb_s_cyc_i & ~wb_s_we_i;
  end

  // Posted-write storage; contents need no reset because the level gates every read of it.
  always_ff @(posedge wb_clk_i) begin
    if (push_s) begin
      adr_mem[wr_ptr_r] <= wb_s_adr_i;
      dat_mem[wr_ptr_r] <= wb_s_dat_i;
      sel_mem[wr_ptr_r] <= wb_s_sel_i;
    end
  end

  // Queue bookkeeping, upstream ack/data and the downstream transfer FSM.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      level_r   <= '0;
      state_r   <= M_IDLE;
      rd_pend_r <= 1'b0;
      s_ack_r   <= 1'b0;
      s_dat_r   <= 32'h0;
      m_adr_r   <= 32'h0;
      m_dat_r   <= 32'h0;
      m_sel_r   <= 4'h0;
      m_we_r    <= 1'b0;
      m_cyc_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      level_r <= level_r + LW'(push_s) - LW'(pop_s);
      s_ack_r <= push_s | rd_deliver_s;

      case (state_r)
        M_IDLE: begin
          // Draining posted writes always wins over a waiting read.
          if (level_r != LW'(0)) begin
            m_adr_r <= adr_mem[rd_ptr_r];
            m_dat_r <= dat_mem[rd_ptr_r];
            m_sel_r <= sel_mem[rd_ptr_r];
            m_we_r  <= 1'b1;
            m_cyc_r <= 1'b1;
            state_r <= M_WRITE;
          end else if (rd_req_s && !rd_pend_r) begin
            m_adr_r   <= wb_s_adr_i;
            m_sel_r   <= wb_s_sel_i;
            m_we_r    <= 1'b0;
            m_cyc_r   <= 1'b1;
            rd_pend_r <= 1'b1;
            state_r   <= M_READ;
          end
        end
        M_WRITE: begin
          if (wb_m_ack_i) begin
            m_cyc_r <= 1'b0;
            state_r <= M_IDLE;
          end
        end
        M_READ: begin
          if (wb_m_ack_i) begin
            s_dat_r   <= wb_m_dat_i;
            m_cyc_r   <= 1'b0;
            rd_pend_r <= 1'b0;
            state_r   <= M_IDLE;
          end
        end
        default: begin
          m_cyc_r   <= 1'b0;
          rd_pend_r <= 1'b0;
          state_r   <= M_IDLE;
        end
      endcase
    end
  end

  assign wb_s_ack_o  = s_ack_r;
  assign wb_s_dat_o  = s_dat_r;
  assign wb_m_adr_o  = m_adr_r;
  assign wb_m_dat_o  = m_dat_r;
  assign wb_m_sel_o  = m_sel_r;
  assign wb_m_we_o   = m_we_r;
  assign wb_m_stb_o  = m_cyc_r;
  assign wb_m_cyc_o  = m_cyc_r;
  assign buf_level_o = level_r;
  assign buf_empty_o = (level_r == LW'(0)) && (state_r == M_IDLE);

endmodule

// File: tb/tb_wb_write_post_buffer.sv
// Bench for wb_write_post_buffer: a latency-programmable downstream slave checks replayed
// writes and reads against a scoreboard filled when upstream stimulus is driven.
module tb_wb_write_post_buffer;

  localparam int DL2 = 2;

  logic        clk;
  logic        rst;
  logic [31:0] s_adr, s_dat, s_dat_o;
  logic [3:0]  s_sel;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [31:0] m_adr, m_dat, m_dat_i;
  logic [3:0]  m_sel;
  logic        m_we, m_stb, m_cyc, m_ack;
  logic [DL2:0] level;
  logic        empty;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];

  int          checks = 0;
  int          failures = 0;
  logic        hold_ack = 1'b0;
  int          ack_lat = 2;
  logic [31:0] rd_data = 32'h0;
  int          wr_acks = 0;
  int          rd_acks = 0;

  wb_write_post_buffer #(.DEPTH_LOG2(DL2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_s_adr_i(s_adr), .wb_s_dat_i(s_dat), .wb_s_sel_i(s_sel), .wb_s_we_i(s_we),
    .wb_s_stb_i(s_stb), .wb_s_cyc_i(s_cyc), .wb_s_dat_o(s_dat_o), .wb_s_ack_o(s_ack),
    .wb_m_adr_o(m_adr), .wb_m_dat_o(m_dat), .wb_m_sel_o(m_sel), .wb_m_we_o(m_we),
    .wb_m_stb_o(m_stb), .wb_m_cyc_o(m_cyc), .wb_m_dat_i(m_dat_i), .wb_m_ack_i(m_ack),
    .buf_level_o(level), .buf_empty_o(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream slave: acks after ack_lat cycles of cyc, checks each transfer against the scoreboard.
  initial begin
    int  cnt;
    wr_t e;
    cnt = 0;
    m_ack = 1'b0;
    m_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (m_ack) begin
        m_ack = 1'b0;
        cnt = 0;
        checks++;
        if (m_cyc !== 1'b0) begin
          failures++;
          $display("FAIL cyc_gap: cyc=%b after ack, required 0", m_cyc);
        end
      end else if (m_cyc && !hold_ack) begin
        cnt++;
        if (cnt >= ack_lat) begin
          m_ack = 1'b1;
          cnt = 0;
          checks++;
          if (m_we) begin
            wr_acks++;
            if (exp_wr.size() == 0) begin
              failures++;
              $display("FAIL wr_replay: unexpected write adr=%h dat=%h", m_adr, m_dat);
            end else begin
              e = exp_wr.pop_front();
              if ({m_stb, m_adr, m_dat, m_sel} !== {1'b1, e.adr, e.dat, e.sel}) begin
                failures++;
                $display("FAIL wr_replay: got stb=%b adr=%h dat=%h sel=%h, required stb=1 adr=%h dat=%h sel=%h",
                         m_stb, m_adr, m_dat, m_sel, e.adr, e.dat, e.sel);
              end
            end
          end else begin
            rd_acks++;
            m_dat_i = rd_data;
            if (exp_rd.size() == 0 || exp_wr.size() != 0) begin
              failures++;
              $display("FAIL rd_issue: read adr=%h with %0d reads expected, %0d writes outstanding (required 1+ and 0)",
                       m_adr, exp_rd.size(), exp_wr.size());
            end else if (m_adr !== exp_rd[0] || m_stb !== 1'b1) begin
              failures++;
              $display("FAIL rd_issue: adr=%h stb=%b, required adr=%h stb=1", m_adr, m_stb, exp_rd[0]);
            end
            if (exp_rd.size() != 0) void'(exp_rd.pop_front());
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    s_adr = a; s_dat = d; s_sel = s; s_we = 1'b1; s_stb = 1'b1; s_cyc = 1'b1;
    e = {a, d, s};
    exp_wr.push_back(e);
  endtask

  task automatic drive_idle();
    s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
  endtask

  task automatic wait_s_ack(input string name, input int budget);
    checks++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (s_ack === 1'b1) return;
    end
    failures++;
    $display("FAIL %s: no upstream ack within %0d cycles, required one", name, budget);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (level == '0 && empty === 1'b1 && m_cyc === 1'b0) break;
    end
    checks++;
    if (level !== '0 || empty !== 1'b1 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: level=%0d empty=%b pending_wr=%0d pending_rd=%0d, required 0 1 0 0",
               name, level, empty, exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset();
    logic [107:0] exp_v;
    exp_v = {3'b000, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 3'd0, 1'b1};
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin
        hold_ack = 1'b1;
        drive_wr(32'h300, 32'h1111_2222, 4'h3);
        wait_s_ack("reset_setup_ack", 20);
        drive_idle();
        for (int i = 0; i < 20 && m_cyc !== 1'b1; i++) @(negedge clk);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, s_ack, s_dat_o, level, empty} !== exp_v) begin
        failures++;
        $display("FAIL reset_%0d: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h ack=%b sdat=%h level=%0d empty=%b, required all 0 and empty=1",
                 ph, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, s_ack, s_dat_o, level, empty);
      end
      rst = 1'b1;
      exp_wr.delete();
      hold_ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_single_write();
    ack_lat = 5;
    drive_wr(32'h100, 32'hA5A5_1234, 4'hF);
    @(negedge clk);
    checks++;
    if (s_ack !== 1'b1 || m_cyc !== 1'b0 || level !== 3'd1) begin
      failures++;
      $display("FAIL single_n1: ack=%b cyc=%b level=%0d, required 1 0 1", s_ack, m_cyc, level);
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if ({s_ack, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, level} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hA5A5_1234, 4'hF, 3'd1}) begin
      failures++;
      $display("FAIL single_n2: ack=%b cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h level=%0d, required 0 1 1 1 100 a5a51234 f 1",
               s_ack, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, level);
    end
    wait_drain("single");
  endtask

  task automatic test_fill();
    bit early;
    ack_lat = 2;
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_wr(32'(i * 4), 32'hF000_0000 | 32'(i), 4'(i + 1));
      wait_s_ack("fill_ack", 20);
    end
    drive_wr(32'h10, 32'hF000_0004, 4'hC);
    early = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s_ack === 1'b1) early = 1'b1;
    end
    checks++;
    if (early || level !== 3'd4) begin
      failures++;
      $display("FAIL fill_full: ack_seen=%b level=%0d, required 0 4", early, level);
    end
    hold_ack = 1'b0;
    wait_s_ack("fill_5th_ack", 100);
    drive_idle();
    wait_drain("fill");
  endtask

  task automatic test_raw();
    int  wr_before, rd_before;
    bit  early;
    ack_lat = 3;
    rd_data = 32'h5A5A_0F0F;
    drive_wr(32'h20, 32'hDEAD_BEEF, 4'hF);
    wait_s_ack("raw_wr_ack", 20);
    wr_before = wr_acks;
    rd_before = rd_acks;
    s_we = 1'b0; s_adr = 32'h20; s_sel = 4'hF;
    exp_rd.push_back(32'h20);
    early = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_acks != rd_before) break;
      if (s_ack === 1'b1) early = 1'b1;
    end
    checks++;
    if (early || wr_acks != wr_before + 1 || rd_acks != rd_before + 1 ||
        s_ack !== 1'b1 || s_dat_o !== 32'h5A5A_0F0F) begin
      failures++;
      $display("FAIL raw_read: early=%b wr_acks=%0d rd_acks=%0d ack=%b dat=%h, required 0 %0d %0d 1 5a5a0f0f",
               early, wr_acks - wr_before, rd_acks - rd_before, s_ack, s_dat_o, 1, 1);
    end
    drive_idle();
    wait_drain("raw");
  endtask

  task automatic test_read_abandon();
    int rd_before;
    bit seen;
    ack_lat = 4;
    rd_data = 32'h1234_5678;
    rd_before = rd_acks;
    s_we = 1'b0; s_adr = 32'h40; s_sel = 4'h6; s_stb = 1'b1; s_cyc = 1'b1;
    exp_rd.push_back(32'h40);
    @(negedge clk);
    checks++;
    if ({m_cyc, m_we, m_adr, m_sel} !== {1'b1, 1'b0, 32'h40, 4'h6}) begin
      failures++;
      $display("FAIL abandon_launch: cyc=%b we=%b adr=%h sel=%h, required 1 0 40 6", m_cyc, m_we, m_adr, m_sel);
    end
    drive_idle();
    seen = 1'b0;
    for (int i = 0; i < 50 && rd_acks == rd_before; i++) begin
      @(negedge clk);
      if (s_ack === 1'b1) seen = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      if (s_ack === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || rd_acks != rd_before + 1 || empty !== 1'b1 || m_cyc !== 1'b0) begin
      failures++;
      $display("FAIL abandon: ack_seen=%b reads=%0d empty=%b cyc=%b, required 0 1 1 0",
               seen, rd_acks - rd_before, empty, m_cyc);
    end
    wait_drain("abandon");
  endtask

  task automatic test_push_pop();
    ack_lat = 1;
    hold_ack = 1'b1;
    drive_wr(32'h200, 32'h0000_0200, 4'h1);
    wait_s_ack("pp_ack0", 20);
    drive_wr(32'h204, 32'h0000_0204, 4'h2);
    wait_s_ack("pp_ack1", 20);
    drive_idle();
    @(negedge clk);
    checks++;
    if (level !== 3'd2 || m_cyc !== 1'b1) begin
      failures++;
      $display("FAIL pp_setup: level=%0d cyc=%b, required 2 1", level, m_cyc);
    end
    drive_wr(32'h208, 32'h0000_0208, 4'h4);
    hold_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 3'd2 || s_ack !== 1'b1) begin
      failures++;
      $display("FAIL pp_level: level=%0d ack=%b, required 2 1", level, s_ack);
    end
    drive_idle();
    wait_drain("pp");
  endtask

  initial begin
    rst = 1'b0;
    s_adr = 32'h0; s_dat = 32'h0; s_sel = 4'h0;
    s_we = 1'b0; s_stb = 1'b0; s_cyc = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_fill();
    test_raw();
    test_read_abandon();
    test_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
